// File: rtl/keypad_pkg.sv
// Shared key-path constants and types for the keypad FIFO and its repeat timer.
package keypad_pkg;

    localparam int unsigned KEY_W            = 5;
    localparam int unsigned DEPTH_DEF        = 8;
    localparam int unsigned REPEAT_DELAY_DEF = 16;
    localparam int unsigned REPEAT_RATE_DEF  = 4;

    typedef logic [KEY_W-1:0] key_code_t;

endpackage

// File: rtl/key_fifo_repeat.sv
// Auto-repeat timer: pulses REPEAT_DELAY cycles after a push edge, then every
// REPEAT_RATE cycles while the strobe stays high. Needs REPEAT_DELAY >= REPEAT_RATE >= 1.
module key_repeat
    import keypad_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic push_edge,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] FIRE   = CNT_W'(REPEAT_DELAY);
    // Reloading here makes the next FIRE land exactly REPEAT_RATE cycles later.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d        = cnt_q;
        repeat_pulse = 1'b0;
        if (!strobe) begin
            cnt_d = '0;
        end else if (push_edge) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == FIRE) begin
            repeat_pulse = 1'b1;
            cnt_d        = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_fifo.sv
// Keypad event FIFO: one push per rising edge of key_strobe, FWFT read port,
// sticky overflow. Define KEY_FIFO_REPEAT_EN to add held-key auto-repeat.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [KEY_W-1:0]         key_code,
    input  logic                     key_strobe,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [KEY_W-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    key_code_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             strb_q, strb_d;

    logic      push_evt, push_req, pop, do_push, drop;
    key_code_t push_code;

    assign push_evt = key_strobe & ~strb_q;
    assign strb_d   = key_strobe;

`ifdef KEY_FIFO_REPEAT_EN
    key_code_t cap_q, cap_d;
    logic      rep_pulse;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_repeat (
        .clk          (clk),
        .rst_n        (rst_n),
        .strobe       (key_strobe),
        .push_edge    (push_evt),
        .repeat_pulse (rep_pulse)
    );

    // Repeats replay the code held at the original press, not the live input.
    assign cap_d     = push_evt ? key_code : cap_q;
    assign push_code = push_evt ? key_code : cap_q;
    assign push_req  = push_evt | rep_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end
`else
    assign push_code = key_code;
    assign push_req  = push_evt;
`endif

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    assign pop     = rd_en & ~empty;
    assign do_push = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            strb_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            strb_q   <= strb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

endmodule

// File: tb/tb_key_fifo.sv
// Scoreboard bench for key_fifo (DEPTH=8, REPEAT_DELAY=16, REPEAT_RATE=4);
// expectations follow KEY_FIFO_REPEAT_EN when the build defines it.
module tb_key_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_code;
    logic       key_strobe;
    logic       rd_en;
    logic       clr_ovf;
    logic [4:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [4:0]  m_q [$];
    logic        m_strb;
    logic        m_ovf;
    logic [4:0]  m_cap;
    int unsigned m_held;

`ifdef KEY_FIFO_REPEAT_EN
    localparam int unsigned RPT_EXP = 5;
`else
    localparam int unsigned RPT_EXP = 1;
`endif

    always #5 clk = ~clk;

    key_fifo #(
        .DEPTH        (8),
        .REPEAT_DELAY (16),
        .REPEAT_RATE  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .rd_en      (rd_en),
        .clr_ovf    (clr_ovf),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow)
    );

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("count", count, m_q.size());
        check_val("empty", empty, (m_q.size() == 0) ? 1 : 0);
        check_val("full", full, (m_q.size() == 8) ? 1 : 0);
        check_val("overflow", overflow, m_ovf);
        check_val("head", rd_data, (m_q.size() != 0) ? int'(m_q[0]) : 0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_strb = 1'b0;
        m_ovf  = 1'b0;
        m_cap  = '0;
        m_held = 0;
    endtask

    // Called at a falling edge: drive one cycle of inputs, predict, check after the rising edge.
    task automatic step(input logic strb, input logic [4:0] code, input logic rd, input logic clr);
        logic       push_evt, rep, push_req, pop, was_full;
        logic [4:0] head;
        key_strobe = strb;
        key_code   = code;
        rd_en      = rd;
        clr_ovf    = clr;
        push_evt   = strb && !m_strb;
        rep        = 1'b0;
`ifdef KEY_FIFO_REPEAT_EN
        if (strb && !push_evt) begin
            m_held++;
            rep = (m_held == 16) || (m_held > 16 && ((m_held - 16) % 4) == 0);
        end
        if (push_evt) m_held = 0;
`endif
        if (push_evt) m_cap = code;
        push_req = push_evt || rep;
        pop      = rd && (m_q.size() != 0);
        was_full = (m_q.size() == 8);
        if (pop) begin
            head = m_q.pop_front();
            check_val("pop_data", rd_data, head);
        end
        if (push_req && (!was_full || pop)) m_q.push_back(m_cap);
        if (push_req && was_full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_strb = strb;
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic push_key(input logic [4:0] code);
        step(1'b1, code, 1'b0, 1'b0);
        step(1'b0, code, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset mid-cycle, held across one rising edge, released at a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        key_code   = '0;
        key_strobe = 1'b0;
        rd_en      = 1'b0;
        clr_ovf    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // held key produces a single entry
        for (int i = 0; i < 5; i++) step(1'b1, 5'd7, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        check_val("single_entry", count, 1);
        drain();

        // fill, overflow, ordered drain, pop while empty
        for (int k = 1; k <= 8; k++) push_key(5'(k));
        push_key(5'd9);
        check_val("ovf_after_drop", overflow, 1);
        drain();

        // simultaneous push and pop while full
        step(1'b0, 5'd0, 1'b0, 1'b1);
        for (int k = 10; k <= 17; k++) push_key(5'(k));
        step(1'b1, 5'd3, 1'b1, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        check_val("full_pushpop_cnt", count, 8);
        drain();

        // push with rd_en while empty
        step(1'b1, 5'd12, 1'b1, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        check_val("empty_push_rd", rd_data, 12);
        drain();

        // clr_ovf coinciding with a dropped push
        for (int k = 20; k <= 27; k++) push_key(5'(k));
        push_key(5'd28);
        step(1'b1, 5'd29, 1'b0, 1'b1);
        check_val("ovf_clr_drop", overflow, 1);
        step(1'b0, 5'd0, 1'b0, 1'b1);
        check_val("ovf_cleared", overflow, 0);
        drain();

        // held key for 30 cycles
        for (int i = 0; i < 30; i++) step(1'b1, 5'd2, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        check_val("repeat_entries", count, RPT_EXP);
        drain();

        // wrap-around traffic
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

        // reset aborts a pending push; strobe high right after release is a press
        push_key(5'd30);
        key_strobe = 1'b1;
        key_code   = 5'd6;
        do_reset();
        step(1'b1, 5'd9, 1'b0, 1'b0);
        check_val("post_reset_push", rd_data, 9);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_fifo.md
KEY_FIFO -- requirements
Module: key_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 16, cycles from first push to first auto-repeat push.
REQ-003 SHALL have parameter REPEAT_RATE, default 4, cycles between subsequent auto-repeat pushes.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_code  input  5  encoded key index from the upstream key encoder.
REQ-007 SHALL have port key_strobe  input  1  level-high while a key is held; key_code is stable whenever it is high.
REQ-008 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-009 SHALL have port clr_ovf  input  1  clears the overflow flag.
REQ-010 SHALL have port rd_data  output  5  head entry (first-word-fall-through); 0 when empty.
REQ-011 SHALL have port empty  output  1  no entries held.
REQ-012 SHALL have port full  output  1  DEPTH entries held.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of entries held.
REQ-014 SHALL have port overflow  output  1  sticky; a push was dropped.

Function
REQ-015 SHALL register key_strobe each cycle (strb_q); a push event occurs in any cycle where key_strobe=1 and strb_q=0.
REQ-016 SHALL write key_code, as sampled in the push-event cycle, into the tail at the next rising edge; count, empty and full update on that same edge.
REQ-017 SHALL present the head on rd_data combinationally from storage; a pop (rd_en=1 and empty=0) advances the head at the clock edge.
REQ-018 SHALL ignore rd_en while empty, with no state change.
REQ-019 SHALL, when push and pop coincide and the FIFO is neither empty nor full, perform both and leave count unchanged.
REQ-020 SHALL, when push and pop coincide while full, perform both, leave count at DEPTH, and not set overflow.
REQ-021 SHALL, when push and rd_en coincide while empty, perform only the push; count becomes 1.
REQ-022 SHALL drop a push that arrives while full without a pop, leave storage unchanged, and set overflow on the next edge.
REQ-023 SHALL hold overflow until a cycle with clr_ovf=1; if clr_ovf and a dropped push coincide, overflow remains 1.
REQ-024 SHALL wrap read and write pointers modulo DEPTH, with full/empty derived from count.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force pointers=0, count=0, empty=1, full=0, overflow=0, rd_data=0, strb_q=0, repeat counter=0.
REQ-026 SHALL treat key_strobe=1 in the first cycle after reset deassertion as a push event, because strb_q resets to 0.
REQ-027 SHALL discard any pending push when rst_n falls mid-operation; storage contents need not be cleared.

Configuration
REQ-028 SHALL, with macro KEY_FIFO_REPEAT_EN defined, start a repeat counter on each push event, issue an extra push of the captured code REPEAT_DELAY cycles later and then every REPEAT_RATE cycles while key_strobe stays 1.
REQ-029 SHALL stop and clear the repeat counter in the cycle key_strobe=0; repeat pushes obey REQ-019..REQ-023 and use the code captured at the original push event.
REQ-030 SHALL, without KEY_FIFO_REPEAT_EN, produce exactly one push per rising edge of key_strobe and contain no repeat logic.

Structure
REQ-031 SHALL take KEY_W=5, typedef key_code_t (logic [KEY_W-1:0]), and DEPTH/REPEAT default constants from shared package keypad_pkg.
REQ-032 SHALL place the repeat timer in sub-module key_repeat (inputs strobe/edge, output repeat pulse), instantiated only under KEY_FIFO_REPEAT_EN.

Verification
REQ-033 SHALL cover: reset, then key_strobe high 5 cycles with key_code=5'd7 -> one entry, count=1, rd_data=7, empty=0.
REQ-034 SHALL cover: push codes 1..8 (DEPTH=8), then code 9 -> full=1, overflow=1, rd_data=1; pop 8 times yields 1..8, then empty=1.
REQ-035 SHALL cover: full FIFO, push code 3 with rd_en=1 in the same cycle -> count stays 8, overflow=0, last entry=3.
REQ-036 SHALL cover: empty FIFO, rd_en=1 with push of code 12 in the same cycle -> count=1, rd_data=12.
REQ-037 SHALL cover: overflow=1, then clr_ovf=1 coinciding with a dropped push -> overflow stays 1; clr_ovf alone next cycle -> overflow=0.
REQ-038 SHALL cover, with KEY_FIFO_REPEAT_EN, REPEAT_DELAY=16, REPEAT_RATE=4: key_strobe held 30 cycles with code 2 -> pushes at edge+1, +17, +21, +25, +29 (5 entries of 2); without the macro, 1 entry.
